sipo_frame_ctrl: RTL
====================

# sipo_frame_ctrl

Frame controller for the 10-bit serial-in/parallel-out shift register (two cascaded '164 stages). It accepts a strobed serial bit stream, forwards exactly one frame of bits into the external SIPO, waits for the shift chain to settle, and captures `Pdata` into a held output word. The word is presented on a valid/ready handshake. It sits between the serial line front end and the parallel consumer and owns every clock-enable and clear decision for the SIPO.

## Interface
- No parameters; frame width is fixed at 10 SIPO bits.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse marking the start of a new frame.
- `ser_in`  in  1  serial data bit.
- `ser_valid`  in  1  `ser_in` is valid this cycle.
- `sipo_sdata`  out  1  registered serial data to SIPO `Sdata`.
- `sipo_shift_en`  out  1  registered shift enable for the SIPO stage.
- `sipo_reset`  out  1  registered synchronous clear for the SIPO.
- `sipo_pdata`  in  10  SIPO parallel output `Pdata[9:0]`.
- `dout`  out  10  captured frame word; first serial bit is in `dout[0]`.
- `dout_valid`  out  1  `dout` holds an unconsumed frame.
- `dout_ready`  in  1  consumer accepts `dout`.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  one-cycle pulse when a `frame_start` is dropped.
- `parity_err`  out  1  parity result for the held word, valid with `dout_valid`.

## Operation
- States: IDLE, SHIFT, DRAIN, HOLD.
- **IDLE to SHIFT:** triggered by `frame_start`.
  - `sipo_reset` is high in the following cycle.
  - The bit counter clears to 0.
  - `ser_valid` in the `frame_start` cycle itself is ignored.
- **SHIFT, data bits:** each `ser_valid` cycle with count below 10:
  - `sipo_sdata` takes `ser_in`, `sipo_shift_en` is 1 next cycle, and the count increments.
  - Bits are forwarded LSB-first; the first bit lands in `Pdata[0]` after 10 shifts.
- **SHIFT, end of frame:** when 10 bits have been accepted (11 with parity, see Configuration), go to DRAIN.
- **DRAIN:** fixed 2 cycles, waiting for the final shift to reach `sipo_pdata`.
  - At the end of the second cycle, `dout` takes `sipo_pdata`.
  - The state then goes to HOLD.
- **HOLD:** `dout_valid` is 1 and `dout` and `parity_err` stay stable.
  - On `dout_valid & dout_ready`, go to IDLE; `dout_valid` drops in the next cycle.
- `sipo_shift_en` is 0 in every cycle not produced by an accepted data bit. `ser_valid` outside SHIFT is ignored.
- **Boundary cases:**
  - `frame_start` in SHIFT: abort the frame, clear the count, pulse `sipo_reset`, and stay in SHIFT for the new frame. A `ser_valid` in the same cycle is ignored. No `overrun`.
  - `frame_start` in DRAIN or HOLD: ignored, with an `overrun` pulse the next cycle. The held or in-flight word is unaffected.
  - `frame_start` together with the `dout_ready` handshake in HOLD: the new frame is accepted and goes to SHIFT, with no `overrun`.
  - `reset` at any time: IDLE and all registers cleared on that edge. A partial frame is discarded.
- **Reset values:** `sipo_sdata`=0, `sipo_shift_en`=0, `sipo_reset`=1 during and one cycle after `reset`, `dout`=0, `dout_valid`=0, `busy`=0, `overrun`=0, `parity_err`=0.

## Timing
- A data bit accepted in cycle t gives `sipo_shift_en` high in t+1 and the SIPO updated in t+2.
- Last forwarded bit accepted in cycle t:
  - DRAIN in t+1 and t+2.
  - `dout` loaded at the end of t+2.
  - `dout_valid` high from t+3.
- Minimum frame-to-frame period is 1 (start) + 10 (bits) + 2 (drain) + 1 (handshake) = 14 cycles without parity, 15 with.
- Bits may be spaced arbitrarily. Gaps in `ser_valid` do not affect the count.

## Configuration
- `SIPO_FRAME_PARITY_EN` defined:
  - A frame is 11 accepted bits; bit 11 is the even-parity bit.
  - Bit 11 is not forwarded: no `sipo_shift_en` for it.
  - The controller keeps a running XOR of the 10 forwarded bits.
  - `parity_err` = XOR of the 10 bits XOR the parity bit, registered into HOLD with `dout`.
- Undefined: a frame is 10 bits and `parity_err` is constant 0.

## Test plan
- **Basic frame:** reset, then `frame_start`, then 10 consecutive bits encoding 0x2B5 LSB-first, `dout_ready`=1.
  - Required: `dout`=0x2B5, with `dout_valid` 3 cycles after the 10th bit for exactly one cycle.
  - Required: exactly 10 `sipo_shift_en` pulses.
- **Backpressure:** as basic frame with `dout_ready`=0 for 20 cycles.
  - Required: `dout_valid` and `dout` held stable.
  - Then a `frame_start` pulse: required `overrun`=1 for one cycle, and `dout` still 0x2B5.
- **Abort:** `frame_start`, 4 bits, then `frame_start` again, then 10 bits of 0x155.
  - Required: `sipo_reset` pulse after each `frame_start`, and `dout`=0x155.
- **Gapped input:** 10 bits of 0x3FF, with `ser_valid` asserted every third cycle.
  - Required: `dout`=0x3FF, and no shift in the non-valid cycles.
- **Reset mid-frame:** `reset` after 6 bits.
  - Required: all outputs at reset values and `busy`=0.
  - Required: a following full frame of 0x001 gives `dout`=0x001.
- **Parity (macro defined):** 0x003 with parity bit 0 gives `parity_err`=0; 0x003 with parity bit 1 gives `parity_err`=1.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Frame controller for a 10-bit external SIPO: forwards one serial frame, drains, captures Pdata.
// Optional even-parity bit per frame when SIPO_FRAME_PARITY_EN is defined.
module sipo_frame_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic       sipo_sdata,
    output logic       sipo_shift_en,
    output logic       sipo_reset,
    input  logic [9:0] sipo_pdata,
    output logic [9:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [3:0] SIPO_BITS = 4'd10;
`ifdef SIPO_FRAME_PARITY_EN
    localparam logic [3:0] FRAME_BITS = 4'd11;
`else
    localparam logic [3:0] FRAME_BITS = 4'd10;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] bit_cnt;
    logic       drain_cnt;

    logic start_frame;
    logic accept_bit;
    logic forward_bit;
    logic load_word;
    logic drop_start;
    logic release_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_frame  = 1'b0;
        accept_bit   = 1'b0;
        forward_bit  = 1'b0;
        load_word    = 1'b0;
        drop_start   = 1'b0;
        release_word = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    start_frame = 1'b1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                // A restart wins over a bit arriving in the same cycle
                if (frame_start) begin
                    start_frame = 1'b1;
                end else if (ser_valid) begin
                    accept_bit  = 1'b1;
                    forward_bit = (bit_cnt < SIPO_BITS);
                    if (bit_cnt == FRAME_BITS - 4'd1) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drop_start = frame_start;
                if (drain_cnt) begin
                    load_word = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (dout_valid && dout_ready) begin
                    release_word = 1'b1;
                    if (frame_start) begin
                        start_frame = 1'b1;
                        state_nxt   = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    drop_start = frame_start;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt       <= 4'd0;
            drain_cnt     <= 1'b0;
            sipo_sdata    <= 1'b0;
            sipo_shift_en <= 1'b0;
            sipo_reset    <= 1'b1;
            overrun       <= 1'b0;
        end else begin
            if (start_frame) begin
                bit_cnt <= 4'd0;
            end else if (accept_bit) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
            if (forward_bit) begin
                sipo_sdata <= ser_in;
            end
            sipo_shift_en <= forward_bit;
            sipo_reset    <= start_frame;
            overrun       <= drop_start;
        end
    end

    // Output word: loaded once the last shift has reached Pdata
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= 10'd0;
            dout_valid <= 1'b0;
        end else begin
            if (load_word) begin
                dout       <= sipo_pdata;
                dout_valid <= 1'b1;
            end else if (release_word) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_FRAME_PARITY_EN
    logic par_acc;
    logic par_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            par_acc    <= 1'b0;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (start_frame) begin
                par_acc <= 1'b0;
                par_bit <= 1'b0;
            end else if (forward_bit) begin
                par_acc <= par_acc ^ ser_in;
            end else if (accept_bit) begin
                par_bit <= ser_in;
            end
            if (load_word) begin
                parity_err <= par_acc ^ par_bit;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
